// File: rtl/raster_pkg.sv
// Shared types, screen defaults and arithmetic helpers for the triangle rasterizer.
package raster_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;

  typedef logic [1:0][9:0]    vertex_t;   // [0]=x, [1]=y
  typedef vertex_t [2:0]      tri_t;
  typedef logic signed [22:0] edge_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LATCH, S_SETUP, S_SCAN, S_EMIT, S_DONE
  } state_t;

  // Eab(p) = (xb-xa)*(py-ya) - (yb-ya)*(px-xa), full precision
  function automatic edge_t edge_fn(input vertex_t a, input vertex_t b,
                                    input logic [9:0] px, input logic [9:0] py);
    logic signed [10:0] dx_ab, dy_ab, dx_ap, dy_ap;
    logic signed [21:0] m0, m1;
    dx_ab = $signed({1'b0, b[0]}) - $signed({1'b0, a[0]});
    dy_ab = $signed({1'b0, b[1]}) - $signed({1'b0, a[1]});
    dx_ap = $signed({1'b0, px})   - $signed({1'b0, a[0]});
    dy_ap = $signed({1'b0, py})   - $signed({1'b0, a[1]});
    m0 = 22'(dx_ab) * 22'(dy_ap);
    m1 = 22'(dy_ab) * 22'(dx_ap);
    return 23'(m0) - 23'(m1);
  endfunction

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/raster_edge_eval.sv
// Combinational edge-function evaluation of a point against a triangle.
module raster_edge_eval
  import raster_pkg::*;
(
  input  vertex_t    i_v0,
  input  vertex_t    i_v1,
  input  vertex_t    i_v2,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output edge_t      o_e01,
  output edge_t      o_e12,
  output edge_t      o_e20,
  output logic       o_inside
);

  logic w_all_ge, w_all_le;

  assign o_e01 = edge_fn(i_v0, i_v1, i_x, i_y);
  assign o_e12 = edge_fn(i_v1, i_v2, i_x, i_y);
  assign o_e20 = edge_fn(i_v2, i_v0, i_x, i_y);

  // Both windings accepted, edges inclusive
  assign w_all_ge = !o_e01[22] && !o_e12[22] && !o_e20[22];
  assign w_all_le = (o_e01[22] || o_e01 == '0) &&
                    (o_e12[22] || o_e12 == '0) &&
                    (o_e20[22] || o_e20 == '0);
  assign o_inside = w_all_ge || w_all_le;

endmodule

// File: rtl/raster_tri.sv
// Pops projected triangles from the FIFO, scans the clamped bounding box and
// emits covered pixels over a valid/ready handshake.
module raster_tri
  import raster_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             raster_start,
  input  logic             proj_done,
  input  logic             fifo_empty,
  output logic             fifo_r,
  input  tri_t             proj_triangle,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             raster_done,
  output logic [CNT_W-1:0] tri_count
);

  localparam logic [9:0] X_LIM = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_LIM = 10'(SCREEN_H - 1);

  state_t     r_state;
  tri_t       r_v;
  logic [9:0] r_xmin, r_xmax, r_ymin, r_ymax, r_x, r_y;

  logic [9:0] w_xmin, w_xmax, w_ymin, w_ymax, w_nx, w_ny;
  logic       w_last, w_inside, w_a_inside, w_degen;
  edge_t      w_e01, w_e12, w_e20, w_a01, w_a12, w_a20;

  raster_edge_eval u_scan (
    .i_v0(r_v[0]), .i_v1(r_v[1]), .i_v2(r_v[2]), .i_x(r_x), .i_y(r_y),
    .o_e01(w_e01), .o_e12(w_e12), .o_e20(w_e20), .o_inside(w_inside)
  );

  // Twice the signed area: E01 evaluated at v2
  raster_edge_eval u_area (
    .i_v0(r_v[0]), .i_v1(r_v[1]), .i_v2(r_v[2]), .i_x(r_v[2][0]), .i_y(r_v[2][1]),
    .o_e01(w_a01), .o_e12(w_a12), .o_e20(w_a20), .o_inside(w_a_inside)
  );

  always_comb begin
    w_xmin  = clamp10(min3(r_v[0][0], r_v[1][0], r_v[2][0]), X_LIM);
    w_xmax  = clamp10(max3(r_v[0][0], r_v[1][0], r_v[2][0]), X_LIM);
    w_ymin  = clamp10(min3(r_v[0][1], r_v[1][1], r_v[2][1]), Y_LIM);
    w_ymax  = clamp10(max3(r_v[0][1], r_v[1][1], r_v[2][1]), Y_LIM);
    w_degen = (w_a01 == '0);
    w_last  = (r_x >= r_xmax) && (r_y >= r_ymax);
    if (r_x < r_xmax) begin
      w_nx = r_x + 10'd1;
      w_ny = r_y;
    end else begin
      w_nx = r_xmin;
      w_ny = r_y + 10'd1;
    end
  end

  // Edge sums are position-invariant; v2 lies on edges 12 and 20
  always_comb begin
    if (!Reset) begin
      assert (25'(w_e01) + 25'(w_e12) + 25'(w_e20) == 25'(w_a01));
      assert (w_a12 == '0 && w_a20 == '0 && w_a_inside);
    end
  end

  assign fifo_r = (r_state == S_CHECK) && !fifo_empty;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_v         <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymin      <= '0;
      r_ymax      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_valid <= 1'b0;
      raster_done <= 1'b0;
      tri_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          tri_count <= '0;
          if (raster_start) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (!fifo_empty) begin
            r_state <= S_LATCH;
          end else if (proj_done) begin
            r_state     <= S_DONE;
            raster_done <= 1'b1;
          end
        end
        S_LATCH: begin
          r_v       <= proj_triangle;
          tri_count <= tri_count + 1'b1;
          r_state   <= S_SETUP;
        end
        S_SETUP: begin
          r_xmin  <= w_xmin;
          r_xmax  <= w_xmax;
          r_ymin  <= w_ymin;
          r_ymax  <= w_ymax;
          r_x     <= w_xmin;
          r_y     <= w_ymin;
          r_state <= w_degen ? S_CHECK : S_SCAN;
        end
        S_SCAN: begin
          if (w_inside) begin
            pixel_x     <= r_x;
            pixel_y     <= r_y;
            pixel_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else if (w_last) begin
            r_state <= S_CHECK;
          end else begin
            r_x <= w_nx;
            r_y <= w_ny;
          end
        end
        S_EMIT: begin
          if (pixel_ready) begin
            pixel_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_CHECK;
            end else begin
              r_x     <= w_nx;
              r_y     <= w_ny;
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          if (!raster_start) begin
            raster_done <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_tri.sv
// Directed bench for raster_tri: vector table per triangle plus backpressure and reset sequences.
module tb_raster_tri;
  import raster_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, raster_start, proj_done, fifo_empty, fifo_r;
  tri_t        proj_triangle;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid, pixel_ready, raster_done;
  logic [15:0] tri_count;

  raster_tri #(.SCREEN_W(640), .SCREEN_H(480), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .raster_start(raster_start), .proj_done(proj_done),
    .fifo_empty(fifo_empty), .fifo_r(fifo_r), .proj_triangle(proj_triangle),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .raster_done(raster_done), .tri_count(tri_count)
  );

  always #5 Clk = ~Clk;

  // FIFO model: pop on fifo_r, data visible the following cycle
  tri_t fifo_mem [0:63];
  int   wr = 0;
  int   rd = 0;
  assign fifo_empty = (rd == wr);
  always @(posedge Clk) begin
    if (fifo_r) begin
      proj_triangle <= fifo_mem[rd];
      rd <= rd + 1;
    end
  end

  // Pixel monitor, sampled mid-cycle
  int mon_x [0:4095];
  int mon_y [0:4095];
  int mon_n = 0;
  always @(negedge Clk) begin
    if (!Reset && pixel_valid && pixel_ready) begin
      mon_x[mon_n] = int'(pixel_x);
      mon_y[mon_n] = int'(pixel_y);
      mon_n++;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic push_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2);
    tri_t t;
    t[0][0] = 10'(x0); t[0][1] = 10'(y0);
    t[1][0] = 10'(x1); t[1][1] = 10'(y1);
    t[2][0] = 10'(x2); t[2][1] = 10'(y2);
    fifo_mem[wr] = t;
    wr++;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (raster_done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(raster_done === 1'b1), 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (pixel_valid !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(pixel_valid === 1'b1), 1);
  endtask

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int n;
    int fx, fy, lx, ly;
  } vec_t;

  vec_t tbl [5];
  int   ref_x [0:15];
  int   ref_y [0:15];

  initial begin
    int base, cnt, maxx, maxy, viol, mism;

    tbl[0] = '{10, 10, 13, 10, 10, 13,   10, 10, 10, 10, 13};  // CCW right triangle
    tbl[1] = '{10, 10, 10, 13, 13, 10,   10, 10, 10, 10, 13};  // same, CW
    tbl[2] = '{0, 0, 5, 5, 9, 9,         0, 0, 0, 0, 0};       // collinear
    tbl[3] = '{700, 500, 800, 500, 700, 600, 0, 0, 0, 0, 0};   // fully off-screen
    tbl[4] = '{600, 400, 700, 400, 600, 500, 3029, 600, 400, 621, 479};

    Reset = 1'b1; raster_start = 1'b0; proj_done = 1'b0; pixel_ready = 1'b1;
    tick(2);
    check("rst_valid", int'(pixel_valid), 0);
    check("rst_fifo_r", int'(fifo_r), 0);
    check("rst_done", int'(raster_done), 0);
    check("rst_count", int'(tri_count), 0);
    check("rst_px", int'(pixel_x), 0);
    Reset = 1'b0;
    tick(2);

    for (int v = 0; v < 5; v++) begin
      base = mon_n;
      push_tri(tbl[v].x0, tbl[v].y0, tbl[v].x1, tbl[v].y1, tbl[v].x2, tbl[v].y2);
      raster_start = 1'b1;
      proj_done    = 1'b1;
      wait_done($sformatf("v%0d_done", v), 20000);
      tick(3);
      check($sformatf("v%0d_done_held", v), int'(raster_done), 1);
      cnt = mon_n - base;
      check($sformatf("v%0d_npix", v), cnt, tbl[v].n);
      check($sformatf("v%0d_tricnt", v), int'(tri_count), 1);
      if (tbl[v].n > 0 && cnt > 0) begin
        check($sformatf("v%0d_first_x", v), mon_x[base], tbl[v].fx);
        check($sformatf("v%0d_first_y", v), mon_y[base], tbl[v].fy);
        check($sformatf("v%0d_last_x", v), mon_x[mon_n-1], tbl[v].lx);
        check($sformatf("v%0d_last_y", v), mon_y[mon_n-1], tbl[v].ly);
      end
      maxx = 0; maxy = 0; viol = 0; mism = 0;
      for (int k = base; k < mon_n; k++) begin
        if (mon_x[k] > maxx) maxx = mon_x[k];
        if (mon_y[k] > maxy) maxy = mon_y[k];
        if (v < 2 && (mon_x[k] - 10) + (mon_y[k] - 10) > 3) viol++;
        if (v < 2 && (mon_x[k] < 10 || mon_y[k] < 10)) viol++;
        if (v == 0 && k - base < 16) begin
          ref_x[k-base] = mon_x[k];
          ref_y[k-base] = mon_y[k];
        end
        if (v == 1 && k - base < 16 &&
            (mon_x[k] != ref_x[k-base] || mon_y[k] != ref_y[k-base])) mism++;
      end
      check($sformatf("v%0d_x_in_screen", v), int'(maxx <= 639), 1);
      check($sformatf("v%0d_y_in_screen", v), int'(maxy <= 479), 1);
      if (v < 2) check($sformatf("v%0d_region", v), viol, 0);
      if (v == 1) check("cw_same_order", mism, 0);
      raster_start = 1'b0;
      proj_done    = 1'b0;
      tick(2);
      check($sformatf("v%0d_done_clr", v), int'(raster_done), 0);
      check($sformatf("v%0d_idle_cnt", v), int'(tri_count), 0);
    end

    // Backpressure on the first pixel, two triangles in one frame
    base = mon_n;
    pixel_ready = 1'b0;
    push_tri(10, 10, 13, 10, 10, 13);
    push_tri(0, 0, 5, 5, 9, 9);
    raster_start = 1'b1;
    wait_valid("bp_valid_wait", 50);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), int'(pixel_valid), 1);
      check($sformatf("bp_x_%0d", i), int'(pixel_x), 10);
      check($sformatf("bp_y_%0d", i), int'(pixel_y), 10);
      tick(1);
    end
    check("bp_no_early_pix", mon_n - base, 0);
    pixel_ready = 1'b1;
    proj_done   = 1'b1;
    wait_done("bp_done", 2000);
    check("bp_npix", mon_n - base, 10);
    check("bp_first_x", mon_x[base], 10);
    check("bp_first_y", mon_y[base], 10);
    check("bp_tricnt", int'(tri_count), 2);
    raster_start = 1'b0;
    proj_done    = 1'b0;
    tick(2);
    check("bp_done_clr", int'(raster_done), 0);

    // Asynchronous reset while a pixel is stalled in Emit
    pixel_ready = 1'b0;
    push_tri(10, 10, 13, 10, 10, 13);
    raster_start = 1'b1;
    proj_done    = 1'b1;
    wait_valid("rs_valid_wait", 50);
    tick(1);
    check("rs_pre_count", int'(tri_count), 1);
    #3 Reset = 1'b1;
    #1;
    check("rs_valid", int'(pixel_valid), 0);
    check("rs_fifo_r", int'(fifo_r), 0);
    check("rs_done", int'(raster_done), 0);
    check("rs_count", int'(tri_count), 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    raster_start = 1'b0;
    push_tri(10, 10, 10, 13, 13, 10);
    tick(3);
    check("rs_idle_no_pop", int'(fifo_r), 0);
    base = mon_n;
    pixel_ready  = 1'b1;
    raster_start = 1'b1;
    wait_done("rs_done_after", 2000);
    check("rs_npix", mon_n - base, 10);
    check("rs_tricnt", int'(tri_count), 1);
    raster_start = 1'b0;
    proj_done    = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
